frequency_generator: RTL and testbench
======================================

FREQUENCY_GENERATOR -- requirements
Module: frequency_generator

Interface
REQ-001 The block SHALL have parameter COUNTER_BITS, default 14: integer bits of the half-period.
REQ-002 The block SHALL have parameter FRAC_BITS, default 3: fractional bits of the half-period, in units of 1/2^FRAC_BITS clock.
REQ-003 Port CLK  in  1: the single clock, 100MHz; all logic on its rising edge.
REQ-004 Port RESETN  in  1: reset, asynchronous assert, active-low.
REQ-005 Port PERIOD_IN  in  COUNTER_BITS+FRAC_BITS: requested half-period, unsigned fixed point, I = upper COUNTER_BITS, F = lower FRAC_BITS.
REQ-006 Port PERIOD_VALID  in  1: PERIOD_IN holds a new value.
REQ-007 Port PERIOD_READY  out  1: pending buffer is empty; a transfer occurs when PERIOD_VALID and PERIOD_READY are high on the same edge.
REQ-008 Port ENABLE  in  1: run request.
REQ-009 Port FREQ_OUT  out  1: generated square wave, registered.
REQ-010 Port EDGE_FLAG  out  1: one-cycle pulse in the cycle FREQ_OUT changes.
REQ-011 Port BUSY  out  1: high in RUN and STOPPING.

Function
REQ-012 The block SHALL hold registers ACTIVE (current half-period), PENDING plus a pending-valid flag, a down-counter CNT (COUNTER_BITS) and a fractional accumulator ACC (FRAC_BITS).
REQ-013 An accepted PERIOD_IN SHALL be written to PENDING and set pending-valid; PERIOD_READY = !pending-valid.
REQ-014 States: IDLE, RUN, STOPPING.
REQ-015 IDLE -> RUN when ENABLE=1 and pending-valid=1: ACTIVE<=PENDING, pending-valid cleared, ACC<=0, CNT<=load value, FREQ_OUT stays 0.
REQ-016 Load value SHALL be max(I,2)+C, where {C,ACC_next} = ACC+F (FRAC_BITS+1-bit sum); ACC<=ACC_next.
REQ-017 In RUN, CNT SHALL decrement each cycle; on the cycle CNT=1 FREQ_OUT toggles, EDGE_FLAG pulses, and CNT reloads per REQ-016.
REQ-018 At each toggle, if pending-valid=1, ACTIVE<=PENDING and pending-valid is cleared before computing that reload, so a new period takes effect on the half-period starting at that toggle; ACC is not cleared.
REQ-019 A PERIOD_VALID transfer coinciding with a toggle that consumes PENDING SHALL be impossible, because PERIOD_READY is 0 whenever pending-valid is 1.
REQ-020 ENABLE=0 in RUN: if FREQ_OUT=0 go to STOPPING, else continue; the next toggle to 0 enters STOPPING.
REQ-021 STOPPING SHALL complete immediately to IDLE with FREQ_OUT=0, CNT=0, ACC=0; ACTIVE is retained.
REQ-022 Re-enable from IDLE with pending-valid=0 SHALL reuse ACTIVE.
REQ-023 Over N half-periods, the total length SHALL equal N*max(I,2)+floor(N*F/2^FRAC_BITS) cycles exactly, with no cumulative drift.
REQ-024 I=0 or 1 SHALL clamp to 2; F is still accumulated.

Reset
REQ-025 RESETN=0 SHALL asynchronously force: state IDLE, FREQ_OUT=0, EDGE_FLAG=0, BUSY=0, PERIOD_READY=1, pending-valid=0, ACTIVE=0, CNT=0, ACC=0.
REQ-026 Reset mid-half-period SHALL abort with no trailing edge; release SHALL be synchronous to CLK.

Configuration
REQ-027 Macro FREQUENCY_GENERATOR_FRAC_EN defined: fractional accumulation per REQ-016.
REQ-028 Macro FREQUENCY_GENERATOR_FRAC_EN undefined: F ignored, C=0, ACC absent; each half-period = max(I,2) cycles. Ports are unchanged.

Verification
REQ-029 PERIOD_IN=20*8+0, ENABLE=1 -> FREQ_OUT period 40 cycles, EDGE_FLAG every 20 cycles.
REQ-030 PERIOD_IN=314*8+4 (314.5) -> half-periods alternate 314,315; 16 half-periods total 5032 cycles; with macro undefined, 5024 cycles.
REQ-031 Running at 20.0, write 10*8+0 mid-half-period -> current half-period completes at 20, next is 10; PERIOD_READY low from the write until that toggle.
REQ-032 PERIOD_IN=1*8+0 -> half-period 2 cycles (clamp).
REQ-033 ENABLE dropped while FREQ_OUT=1 -> one more falling edge, then BUSY=0 and FREQ_OUT=0 held.
REQ-034 RESETN pulsed low mid-run -> FREQ_OUT=0 and PERIOD_READY=1 immediately; no EDGE_FLAG until re-enabled with a new period.

Source files
------------

// File: rtl/frequency_generator_if.sv
// Period/enable handshake and generated-output bundle for frequency_generator.
// PERIOD_IN is unsigned fixed point: upper COUNTER_BITS integer, lower FRAC_BITS fraction.
interface frequency_generator_if #(
  parameter int COUNTER_BITS = 14,
  parameter int FRAC_BITS    = 3
);
  logic [COUNTER_BITS+FRAC_BITS-1:0] PERIOD_IN;
  logic                              PERIOD_VALID;
  logic                              PERIOD_READY;
  logic                              ENABLE;
  logic                              FREQ_OUT;
  logic                              EDGE_FLAG;
  logic                              BUSY;

  modport master (
    output PERIOD_IN, PERIOD_VALID, ENABLE,
    input  PERIOD_READY, FREQ_OUT, EDGE_FLAG, BUSY
  );

  modport slave (
    input  PERIOD_IN, PERIOD_VALID, ENABLE,
    output PERIOD_READY, FREQ_OUT, EDGE_FLAG, BUSY
  );
endinterface

// File: rtl/frequency_generator.sv
// Square-wave generator with fixed-point half-period and a one-deep pending period buffer.
// Define FREQUENCY_GENERATOR_FRAC_EN to enable fractional half-period accumulation.
//
// state    | meaning
// IDLE     | output low, waiting for ENABLE and a known period
// RUN      | counting half-periods, toggling FREQ_OUT
// STOPPING | one cycle of cleanup back to IDLE
module frequency_generator #(
  parameter int COUNTER_BITS = 14,
  parameter int FRAC_BITS    = 3
) (
  input logic                  CLK,
  input logic                  RESETN,
  frequency_generator_if.slave bus
);
  localparam int W = COUNTER_BITS + FRAC_BITS;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_STOP = 2'd2;

  logic [1:0]              r_rst_sync;
  logic                    w_rst_n;
  logic [1:0]              r_state;
  logic [W-1:0]            r_active;
  logic [W-1:0]            r_pending;
  logic                    r_pend_vld;
  logic                    r_active_vld;
  logic [COUNTER_BITS-1:0] r_cnt;
  logic                    r_freq;
  logic                    r_edge;

  logic                    w_take;
  logic                    w_start;
  logic                    w_stop_now;
  logic                    w_tc;
  logic                    w_toggle;
  logic [W-1:0]            w_src;
  logic [COUNTER_BITS-1:0] w_int;
  logic [COUNTER_BITS-1:0] w_base_len;
  logic [COUNTER_BITS-1:0] w_load;

  // Reset asserts immediately but releases only on a clock edge.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) r_rst_sync <= 2'b00;
    else         r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_take     = bus.PERIOD_VALID && !r_pend_vld;
  assign w_start    = bus.ENABLE && (r_pend_vld || r_active_vld);
  assign w_stop_now = !bus.ENABLE && !r_freq;
  assign w_tc       = (r_cnt == COUNTER_BITS'(1));
  assign w_toggle   = w_tc && !w_stop_now;
  // A pending period always wins: it is consumed at the same edge its reload is computed.
  assign w_src      = r_pend_vld ? r_pending : r_active;
  assign w_int      = w_src[W-1:FRAC_BITS];
  assign w_base_len = (w_int < COUNTER_BITS'(2)) ? COUNTER_BITS'(2) : w_int;

`ifdef FREQUENCY_GENERATOR_FRAC_EN
  logic [FRAC_BITS-1:0] r_acc;
  logic [FRAC_BITS-1:0] w_acc_base;
  logic [FRAC_BITS-1:0] w_acc_next;
  logic                 w_carry;

  assign w_acc_base = (r_state == S_IDLE) ? '0 : r_acc;
  assign {w_carry, w_acc_next} = {1'b0, w_acc_base} + {1'b0, w_src[FRAC_BITS-1:0]};
  assign w_load = w_base_len + COUNTER_BITS'(w_carry);

  always_ff @(posedge CLK or negedge w_rst_n) begin
    if (!w_rst_n)
      r_acc <= '0;
    else if (r_state == S_STOP)
      r_acc <= '0;
    else if ((r_state == S_IDLE && w_start) || (r_state == S_RUN && w_toggle))
      r_acc <= w_acc_next;
  end
`else
  logic w_unused_frac;
  assign w_unused_frac = ^w_src[FRAC_BITS-1:0];
  assign w_load        = w_base_len;
`endif

  always_ff @(posedge CLK or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state      <= S_IDLE;
      r_active     <= '0;
      r_pending    <= '0;
      r_pend_vld   <= 1'b0;
      r_active_vld <= 1'b0;
      r_cnt        <= '0;
      r_freq       <= 1'b0;
      r_edge       <= 1'b0;
    end else begin
      r_edge <= 1'b0;
      if (w_take) begin
        r_pending  <= bus.PERIOD_IN;
        r_pend_vld <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state      <= S_RUN;
            r_active     <= w_src;
            r_active_vld <= 1'b1;
            r_cnt        <= w_load;
            if (r_pend_vld) r_pend_vld <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_stop_now) begin
            r_state <= S_STOP;
          end else if (w_tc) begin
            r_freq <= !r_freq;
            r_edge <= 1'b1;
            r_cnt  <= w_load;
            if (r_pend_vld) begin
              r_active   <= r_pending;
              r_pend_vld <= 1'b0;
            end
            if (r_freq && !bus.ENABLE) r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt - COUNTER_BITS'(1);
          end
        end
        S_STOP: begin
          r_state <= S_IDLE;
          r_freq  <= 1'b0;
          r_cnt   <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.PERIOD_READY = !r_pend_vld;
  assign bus.FREQ_OUT     = r_freq;
  assign bus.EDGE_FLAG    = r_edge;
  assign bus.BUSY         = (r_state != S_IDLE);
endmodule

// File: tb/tb_frequency_generator.sv
// Self-checking bench for frequency_generator: half-period lengths compared against
// an arithmetic model of the cumulative fixed-point period.
module tb_frequency_generator;
  localparam int CB = 14;
  localparam int FB = 3;
  localparam int W  = CB + FB;
`ifdef FREQUENCY_GENERATOR_FRAC_EN
  localparam bit FRAC_ON = 1'b1;
`else
  localparam bit FRAC_ON = 1'b0;
`endif

  logic CLK    = 1'b0;
  logic RESETN = 1'b0;

  frequency_generator_if #(.COUNTER_BITS(CB), .FRAC_BITS(FB)) bus ();
  frequency_generator #(.COUNTER_BITS(CB), .FRAC_BITS(FB)) dut (
    .CLK(CLK),
    .RESETN(RESETN),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int m_i, m_f, m_s, m_lvl;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Length of the next half-period: integer part clamped to 2, plus the carry out of
  // the running fraction sum since the run started.
  function automatic int next_len();
    int feff, lo;
    feff = FRAC_ON ? m_f : 0;
    lo   = m_s / (1 << FB);
    m_s += feff;
    return ((m_i < 2) ? 2 : m_i) + m_s / (1 << FB) - lo;
  endfunction

  task automatic wait_edge(output int n);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!bus.EDGE_FLAG && n < 20000);
    if (!bus.EDGE_FLAG) check("edge_timeout", n, 0);
  endtask

  task automatic set_period(input int i, input int f);
    bus.PERIOD_IN    = W'(i * (1 << FB) + f);
    bus.PERIOD_VALID = 1'b1;
    @(negedge CLK);
    bus.PERIOD_VALID = 1'b0;
  endtask

  task automatic start_run(input int i, input int f, output int first);
    int n;
    check("ready_before_load", bus.PERIOD_READY, 1);
    set_period(i, f);
    m_i = i; m_f = f; m_s = 0; m_lvl = 0;
    bus.ENABLE = 1'b1;
    wait_edge(n);
    first = n - 1;
    check("first_half", first, next_len());
    m_lvl ^= 1;
    check("first_level", bus.FREQ_OUT, m_lvl);
  endtask

  task automatic run_halves(input int k, input string tag, output int sum);
    int n;
    sum = 0;
    for (int h = 0; h < k; h++) begin
      wait_edge(n);
      sum += n;
      check(tag, n, next_len());
      m_lvl ^= 1;
      check({tag, "_level"}, bus.FREQ_OUT, m_lvl);
    end
  endtask

  task automatic stop_run();
    int n, edges;
    bus.ENABLE = 1'b0;
    if (m_lvl == 1) begin
      wait_edge(n);
      check("stop_tail", n, next_len());
      m_lvl = 0;
      check("stop_tail_level", bus.FREQ_OUT, 0);
      @(negedge CLK);
    end else begin
      @(negedge CLK);
      @(negedge CLK);
    end
    check("busy_off", bus.BUSY, 0);
    edges = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge CLK);
      if (bus.EDGE_FLAG || bus.FREQ_OUT) edges++;
    end
    check("idle_quiet", edges, 0);
  endtask

  task automatic mid_change(input int i2, input int f2, input int max_d, input string tag);
    int len, d, n, s;
    len = next_len();
    d = $urandom_range(0, ((len - 2) < max_d) ? (len - 2) : max_d);
    repeat (d) @(negedge CLK);
    set_period(i2, f2);
    check({tag, "_ready_low"}, bus.PERIOD_READY, 0);
    wait_edge(n);
    check({tag, "_cur"}, d + 1 + n, len);
    check({tag, "_ready_back"}, bus.PERIOD_READY, 1);
    m_lvl ^= 1;
    m_i = i2; m_f = f2;
    run_halves(2, {tag, "_new"}, s);
  endtask

  initial begin
    int first, sum, edges, ri, rf, k;
    bus.PERIOD_IN    = '0;
    bus.PERIOD_VALID = 1'b0;
    bus.ENABLE       = 1'b0;
    #1;
    check("rst_ready", bus.PERIOD_READY, 1);
    check("rst_freq", bus.FREQ_OUT, 0);
    check("rst_edge", bus.EDGE_FLAG, 0);
    check("rst_busy", bus.BUSY, 0);
    repeat (3) @(negedge CLK);
    RESETN = 1'b1;
    repeat (4) @(negedge CLK);

    // 20.0: half-period 20, period 40
    start_run(20, 0, first);
    run_halves(5, "p20", sum);
    stop_run();

    // 314.5: 16 half-periods
    start_run(314, 4, first);
    run_halves(15, "p314", sum);
    check("p314_total16", first + sum, FRAC_ON ? 5032 : 5024);
    stop_run();

    // clamp 1.0 -> 2, stop while output high
    start_run(1, 0, first);
    run_halves(2, "clamp", sum);
    stop_run();

    // re-enable without a new period reuses the active one
    m_s = 0; m_lvl = 0;
    bus.ENABLE = 1'b1;
    wait_edge(first);
    check("reuse_first", first - 1, next_len());
    m_lvl ^= 1;
    run_halves(1, "reuse", sum);
    stop_run();

    // period update mid half-period
    start_run(20, 0, first);
    mid_change(10, 0, 15, "chg");
    stop_run();

    // randomized periods, optional mid-run updates
    for (int t = 0; t < 8; t++) begin
      ri = $urandom_range(0, 50);
      rf = $urandom_range(0, 7);
      k  = $urandom_range(1, 6);
      start_run(ri, rf, first);
      run_halves(k, "rnd", sum);
      if ($urandom_range(0, 1) == 1)
        mid_change($urandom_range(0, 40), $urandom_range(0, 7), 60, "rnd_chg");
      stop_run();
    end

    // reset mid-run
    start_run(30, 0, first);
    run_halves(1, "pre_rst", sum);
    repeat (7) @(negedge CLK);
    RESETN = 1'b0;
    #1;
    check("midrst_freq", bus.FREQ_OUT, 0);
    check("midrst_ready", bus.PERIOD_READY, 1);
    check("midrst_busy", bus.BUSY, 0);
    @(negedge CLK);
    RESETN = 1'b1;
    edges = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      if (bus.EDGE_FLAG) edges++;
    end
    check("post_rst_quiet", edges, 0);
    check("post_rst_busy", bus.BUSY, 0);
    start_run(12, 0, first);
    run_halves(2, "post_rst", sum);
    stop_run();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
